// File: rtl/text_vga_ctrl.sv
// rtl/text_vga_ctrl.sv - VGA text-mode controller with cell/glyph fetch, colour, blink, cursor and scroll
module text_vga_ctrl #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLINK_FRAMES = 32,
    localparam int AW          = $clog2(COLS * ROWS),
    localparam int GW          = 8 + $clog2(CHAR_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic [AW-1:0]     ram_addr,
    input  logic [15:0]       ram_q,
    output logic [GW-1:0]     glyph_addr,
    input  logic [CHAR_W-1:0] glyph_q,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [2:0]        vga_rgb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int HW      = $clog2(CHAR_H);
    localparam int CW      = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          wrap;
    logic [FW-1:0] frame_q;
    logic          blink_phase_q;
    logic [7:0]    cur_col_q, cur_row_q, scroll_pend_q, scroll_live_q, scroll_live_d;
    logic          blink_en_q, cursor_en_q;
    logic [AW-1:0] ram_addr_q, ram_addr_d;

    logic          s0_valid, s0_cur, s0_hs, s0_vs;
    logic [CW-1:0] s0_cx;
    logic [HW-1:0] s0_cy;
    logic          s1_valid_q, s1_cur_q, s1_hs_q, s1_vs_q;
    logic [CW-1:0] s1_cx_q;
    logic [HW-1:0] s1_cy_q;
    logic          s2_valid_q, s2_cur_q, s2_hs_q, s2_vs_q;
    logic [CW-1:0] s2_cx_q;
    logic [6:0]    s2_attr_q;
    logic [2:0]    rgb_d, rgb_q;
    logic          hsync_q, vsync_q;
    logic          unused_attr_bit;

    assign unused_attr_bit = ram_q[11];

    always_comb begin
        wrap = 1'b0;
        x_d  = x_q + 1'b1;
        y_d  = y_q;
        if (int'(x_q) == H_TOTAL - 1) begin
            x_d = '0;
            if (int'(y_q) == V_TOTAL - 1) begin
                y_d  = '0;
                wrap = 1'b1;
            end else begin
                y_d = y_q + 1'b1;
            end
        end
        scroll_live_d = wrap ? scroll_pend_q : scroll_live_q;
    end

    // Address is computed from the next counter state so ram_addr_q lines up with x_q/y_q.
    always_comb begin
        int col_n, line_n, row_n;
        col_n  = int'(x_d) / CHAR_W;
        line_n = int'(y_d) / CHAR_H;
        row_n  = line_n + int'(scroll_live_d);
        if (row_n >= ROWS) row_n = row_n - ROWS;
        ram_addr_d = '0;
        if (col_n < COLS && line_n < ROWS) ram_addr_d = AW'(row_n * COLS + col_n);
    end

    always_comb begin
        int col_c, line_c;
        col_c    = int'(x_q) / CHAR_W;
        line_c   = int'(y_q) / CHAR_H;
        s0_cx    = CW'(int'(x_q) % CHAR_W);
        s0_cy    = y_q[HW-1:0];
        s0_valid = int'(x_q) < H_ACTIVE && int'(y_q) < V_ACTIVE && col_c < COLS && line_c < ROWS;
        s0_cur   = cursor_en_q && col_c == int'(cur_col_q) && line_c == int'(cur_row_q)
                   && int'(s0_cy) >= CHAR_H - 2;
        s0_hs    = !(int'(x_q) >= H_ACTIVE + H_FP && int'(x_q) < H_ACTIVE + H_FP + H_SYNC);
        s0_vs    = !(int'(y_q) >= V_ACTIVE + V_FP && int'(y_q) < V_ACTIVE + V_FP + V_SYNC);
    end

    // Gating on the stage-1 valid flag keeps the ROM address at 0 during reset and blanking.
    assign glyph_addr = s1_valid_q ? {ram_q[7:0], s1_cy_q} : '0;

    always_comb begin
        logic [2:0] fg, bg;
        logic       pix;
        fg = s2_attr_q[2:0];
        bg = s2_attr_q[5:3];
        if (blink_en_q && s2_attr_q[6] && !blink_phase_q) fg = bg;
        pix   = glyph_q[CW'(CHAR_W - 1) - s2_cx_q] || (s2_cur_q && blink_phase_q);
        rgb_d = '0;
        if (s2_valid_q) rgb_d = pix ? fg : bg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
            cur_col_q     <= '0;
            cur_row_q     <= '0;
            scroll_pend_q <= '0;
            scroll_live_q <= '0;
            blink_en_q    <= 1'b0;
            cursor_en_q   <= 1'b0;
            ram_addr_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_cur_q      <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            s1_cx_q       <= '0;
            s1_cy_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_cur_q      <= 1'b0;
            s2_hs_q       <= 1'b1;
            s2_vs_q       <= 1'b1;
            s2_cx_q       <= '0;
            s2_attr_q     <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            scroll_live_q <= scroll_live_d;
            ram_addr_q    <= ram_addr_d;
            if (wrap) begin
                frame_q <= frame_q + 1'b1;
                if (frame_q == FW'(BLINK_FRAMES - 1)) blink_phase_q <= !blink_phase_q;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: cur_col_q <= cfg_wdata;
                    2'd1: cur_row_q <= cfg_wdata;
                    2'd2: begin
                        blink_en_q  <= cfg_wdata[1];
                        cursor_en_q <= cfg_wdata[0];
                    end
                    2'd3: if (int'(cfg_wdata) < ROWS) scroll_pend_q <= cfg_wdata;
                endcase
            end
            s1_valid_q <= s0_valid;
            s1_cur_q   <= s0_cur;
            s1_hs_q    <= s0_hs;
            s1_vs_q    <= s0_vs;
            s1_cx_q    <= s0_cx;
            s1_cy_q    <= s0_cy;
            s2_valid_q <= s1_valid_q;
            s2_cur_q   <= s1_cur_q;
            s2_hs_q    <= s1_hs_q;
            s2_vs_q    <= s1_vs_q;
            s2_cx_q    <= s1_cx_q;
            s2_attr_q  <= {ram_q[15], ram_q[14:12], ram_q[10:8]};
            rgb_q      <= rgb_d;
            hsync_q    <= s2_hs_q;
            vsync_q    <= s2_vs_q;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign vga_rgb   = rgb_q;
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
endmodule

// File: tb/tb_text_vga_ctrl.sv
// tb/tb_text_vga_ctrl.sv - directed vector bench for text_vga_ctrl on a reduced 56x22 raster
module tb_text_vga_ctrl;
    localparam int F       = 56 * 22;
    localparam int K_RGB   = 0;
    localparam int K_HS    = 1;
    localparam int K_VS    = 2;
    localparam int K_RAM   = 3;
    localparam int K_GLYPH = 4;

    typedef struct {
        int n;
        int kind;
        int exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [3:0] ram_addr;
    logic [15:0] ram_q;
    logic [9:0] glyph_addr;
    logic [7:0] glyph_q;
    logic       vga_hsync, vga_vsync;
    logic [2:0] vga_rgb;

    logic [15:0] mem [16];
    logic [7:0]  font [1024];
    int cyc = 0;
    int tests = 0;
    int failures = 0;
    vec_t vecs [23];

    text_vga_ctrl #(
        .COLS(4), .ROWS(3), .CHAR_W(8), .CHAR_H(4),
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .ram_addr(ram_addr), .ram_q(ram_q), .glyph_addr(glyph_addr), .glyph_q(glyph_q),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_q   <= mem[ram_addr];
        glyph_q <= font[glyph_addr];
        cyc     <= rst ? 0 : cyc + 1;
    end

    function automatic string kname(input int k);
        case (k)
            K_RGB:   return "rgb";
            K_HS:    return "hsync";
            K_VS:    return "vsync";
            K_RAM:   return "ram_addr";
            default: return "glyph_addr";
        endcase
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int s);
        while (cyc < s) @(negedge clk);
    endtask

    task automatic check_at(input int n, input int kind, input int exp);
        int s;
        int act;
        s = n + ((kind == K_RAM) ? 0 : (kind == K_GLYPH) ? 1 : 3);
        wait_cyc(s);
        case (kind)
            K_RGB:   act = int'(vga_rgb);
            K_HS:    act = int'(vga_hsync);
            K_VS:    act = int'(vga_vsync);
            K_RAM:   act = int'(ram_addr);
            default: act = int'(glyph_addr);
        endcase
        if (cyc != s) act = -1;
        cmp($sformatf("%s@%0d", kname(kind), n), act, exp);
    endtask

    task automatic cfg_at(input int s, input logic [1:0] a, input logic [7:0] d);
        wait_cyc(s);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 1024; i++) font[i] = 8'h00;
        mem[0] = 16'h1741;
        mem[2] = 16'h8741;
        mem[4] = 16'h3441;
        mem[5] = 16'h2500;
        mem[6] = 16'h6041;
        font[16'h41 * 4] = 8'h80;

        // {counter index, output, expected}, in sampling order; frame 0, scroll 0, blink/cursor off
        vecs = '{
            '{0, K_GLYPH, 260}, '{0, K_RGB, 7}, '{1, K_RGB, 1}, '{16, K_RGB, 7},
            '{33, K_RAM, 0}, '{32, K_RGB, 0}, '{43, K_HS, 1}, '{44, K_HS, 0},
            '{49, K_HS, 0}, '{50, K_HS, 1}, '{224, K_RAM, 4}, '{224, K_RGB, 4},
            '{225, K_RGB, 3}, '{344, K_GLYPH, 2}, '{344, K_RGB, 2}, '{457, K_RAM, 9},
            '{672, K_RGB, 0}, '{1007, K_VS, 1}, '{1008, K_VS, 0}, '{1119, K_VS, 0},
            '{1120, K_VS, 1}, '{1232, K_RGB, 7}, '{1233, K_RGB, 1}
        };

        @(negedge clk);
        cmp("reset hsync", int'(vga_hsync), 1);
        cmp("reset vsync", int'(vga_vsync), 1);
        cmp("reset rgb", int'(vga_rgb), 0);
        cmp("reset ram_addr", int'(ram_addr), 0);
        cmp("reset glyph_addr", int'(glyph_addr), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) check_at(vecs[i].n, vecs[i].kind, vecs[i].exp);

        // cursor at (1,1), blink and cursor enabled; phase 0 in frame 1, 1 in frames 2-3
        cfg_at(1240, 2'd0, 8'd1);
        cfg_at(1241, 2'd1, 8'd1);
        cfg_at(1242, 2'd2, 8'h03);
        check_at(F + 16, K_RGB, 0);
        check_at(F + 344, K_RGB, 2);
        check_at(2 * F + 16, K_RGB, 7);
        check_at(2 * F + 288, K_RGB, 2);
        check_at(2 * F + 344, K_RGB, 5);
        check_at(2 * F + 352, K_RGB, 6);
        check_at(2 * F + 407, K_RGB, 5);
        cfg_at(3 * F + 10, 2'd2, 8'h00);
        check_at(3 * F + 16, K_RGB, 7);
        check_at(3 * F + 344, K_RGB, 2);
        check_at(4 * F + 16, K_RGB, 7);

        // scroll: pending until wrap, out-of-range ignored, write on the wrap cycle deferred a frame
        cfg_at(5 * F + 100, 2'd3, 8'd1);
        check_at(5 * F + 224, K_RAM, 4);
        check_at(6 * F, K_RAM, 4);
        check_at(6 * F, K_RGB, 4);
        check_at(6 * F + 456, K_RAM, 1);
        cfg_at(6 * F + 500, 2'd3, 8'd3);
        check_at(7 * F, K_RAM, 4);
        cfg_at(8 * F - 1, 2'd3, 8'd2);
        check_at(8 * F, K_RAM, 4);
        check_at(9 * F, K_RAM, 8);
        check_at(9 * F + 232, K_RAM, 1);

        // one-cycle reset mid-line
        wait_cyc(9 * F + 242);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("midreset cyc", cyc, 0);
        cmp("midreset hsync", int'(vga_hsync), 1);
        cmp("midreset vsync", int'(vga_vsync), 1);
        cmp("midreset rgb", int'(vga_rgb), 0);
        cmp("midreset ram_addr", int'(ram_addr), 0);
        check_at(0, K_RGB, 7);
        check_at(44, K_HS, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
